// File: rtl/uart_tx_buffered_if.sv
// Producer-side bus of the buffered UART transmitter: push handshake plus line/status outputs.
interface uart_tx_buffered_if #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                                send;
  logic [WIDTH-1:0]                    dataIn;
  logic                                ready;
  logic                                dataOut;
  logic                                busy;
  logic [$clog2(FIFO_DEPTH+1)-1:0]     fifoCount;

  modport master (
    output send, dataIn,
    input  ready, dataOut, busy, fifoCount
  );

  modport slave (
    input  send, dataIn,
    output ready, dataOut, busy, fifoCount
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// UART transmitter with an input FIFO: start, LSB-first data, optional parity, 1-2 stop bits,
// frames sent back-to-back while words are queued.
module uart_tx_buffered #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_buffered_if.slave    txIf
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  if (PARITY < 0 || PARITY > 2) begin : gBadParity
    $error("uart_tx_buffered: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : gBadStop
    $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
    $error("uart_tx_buffered: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (WIDTH < 5 || CLKS_PER_BIT < 2) begin : gBadGeom
    $error("uart_tx_buffered: WIDTH must be >= 5 and CLKS_PER_BIT >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             push, pop;
  logic [WIDTH-1:0] headWord;

  state_t           state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0] bitCnt_q, bitCnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             parBit_q, parBit_d;
  logic             dataOut_q, dataOut_d;
  logic             baudEnd;

  assign txIf.ready     = !reset && (count_q < DEPTH_C);
  assign push           = txIf.send && txIf.ready;
  assign headWord       = mem_q[rdPtr_q];
  assign baudEnd        = (baud_q == BAUD_LAST);
  assign txIf.dataOut   = dataOut_q;
  assign txIf.busy      = (state_q != S_IDLE);
  assign txIf.fifoCount = count_q;

  // Storage needs no reset: a slot is only read after a push has written it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= txIf.dataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      parBit_q  <= 1'b0;
      dataOut_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      parBit_q  <= parBit_d;
      dataOut_q <= dataOut_d;
    end
  end

  // dataOut_d is the line level for the bit period that begins at the coming edge.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    parBit_d  = parBit_q;
    dataOut_d = dataOut_q;
    pop       = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = baudEnd ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        dataOut_d = 1'b1;
        if (count_q != '0) begin
          pop       = 1'b1;
          shift_d   = headWord;
          parBit_d  = (PARITY == 1) ? ^headWord : ~^headWord;
          dataOut_d = 1'b0;
          baud_d    = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (baudEnd) begin
          dataOut_d = shift_q[0];
          shift_d   = shift_q >> 1;
          bitCnt_d  = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baudEnd) begin
          if (bitCnt_q == DATA_LAST) begin
            bitCnt_d = '0;
            if (PARITY != 0) begin
              dataOut_d = parBit_q;
              state_d   = S_PARITY;
            end else begin
              dataOut_d = 1'b1;
              state_d   = S_STOP;
            end
          end else begin
            dataOut_d = shift_q[0];
            shift_d   = shift_q >> 1;
            bitCnt_d  = bitCnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baudEnd) begin
          dataOut_d = 1'b1;
          bitCnt_d  = '0;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (baudEnd) begin
          if (bitCnt_q == STOP_LAST) begin
            // Reload straight into the next start bit so queued frames leave no idle gap.
            if (count_q != '0) begin
              pop       = 1'b1;
              shift_d   = headWord;
              parBit_d  = (PARITY == 1) ? ^headWord : ~^headWord;
              dataOut_d = 1'b0;
              state_d   = S_START;
            end else begin
              dataOut_d = 1'b1;
              state_d   = S_IDLE;
            end
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        dataOut_d = 1'b1;
      end
    endcase
  end

endmodule
